alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the team's 16-bit combinational ALU. Widens operand width via `WIDTH`, extends the op set to 3-bit control, and adds iterative multiply and divide with valid/ready flow control on both sides. Sits between the datapath register file and the writeback stage. Holds one operation in flight and registers its result and flags until consumed.

## Interface
Parameters:
- `WIDTH`, default 16: operand and result width in bits; legal range is 4 to 64.

Ports:
- `clk`, input, 1 bit: single clock; all state updates on its rising edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `in_valid`, input, 1 bit: request present.
- `in_ready`, output, 1 bit: block can accept a request.
- `ctrl`, input, 3 bits: op select, sampled on accept.
- `input_a`, input, `WIDTH` bits: operand A, sampled on accept.
- `input_b`, input, `WIDTH` bits: operand B, sampled on accept.
- `out_valid`, output, 1 bit: result and flags valid.
- `out_ready`, input, 1 bit: consumer takes the result.
- `alu_result`, output, `WIDTH` bits: registered result.
- `LT`, output, 1 bit: signed A < B, registered.
- `zero`, output, 1 bit: `alu_result == 0`.
- `carry`, output, 1 bit: ADD carry-out, or SUB unsigned borrow (A < B); 0 for all other ops.
- `div_zero`, output, 1 bit: DIV with B == 0.

## Operation
- Accept occurs when `in_valid && in_ready`. `ctrl`, A and B are latched at accept; inputs may change afterwards without effect.
- Op encoding:
  - 000 ADD: A+B, modulo 2^WIDTH.
  - 001 SUB: A−B, modulo 2^WIDTH.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: result = zero-extended `LT`.
  - 110 MUL: unsigned, low `WIDTH` bits of the product.
  - 111 DIV: unsigned quotient; the remainder is discarded.
- FSM states:
  - IDLE: `in_ready` = 1.
    - Accept of ops 000–101 → DONE.
    - Accept of MUL → MUL.
    - Accept of DIV → DIV.
  - MUL: shift-add, one multiplier bit per cycle. A bit counter runs WIDTH−1 down to 0; reaching 0 → DONE.
  - DIV: restoring division, one quotient bit per cycle, same counter. Reaching 0 → DONE.
    - If B == 0 at accept, go straight to DONE with result all-ones and `div_zero` = 1.
  - DONE: `out_valid` = 1. On `out_ready` → IDLE.
- `in_ready` is high only in IDLE. No accept occurs in the same cycle as a result handoff.
- `LT`, `zero`, `carry` and `div_zero` are updated together with `alu_result` on entry to DONE. They hold until the next DONE entry.

## Timing
- Reset values (next edge with `reset` = 1): state IDLE, `in_ready` = 1, `out_valid` = 0, `alu_result` = 0, `LT` = 0, `zero` = 0, `carry` = 0, `div_zero` = 0, counter = 0.
- Reset during MUL or DIV abandons the operation: no `out_valid`, and the partial result is discarded.
- Latency is measured from the accept edge to `out_valid` high:
  - Ops 000–101: 1 cycle.
  - MUL: WIDTH+1 cycles.
  - DIV: WIDTH+1 cycles.
  - DIV by zero: 1 cycle.
- Minimum throughput: one simple op per 2 cycles (accept, then handoff).
- Backpressure: while `out_valid && !out_ready`, all outputs stay stable and `in_ready` stays 0.
- `in_valid` asserted outside IDLE is ignored; the request must be held until `in_ready`.
- Boundaries:
  - ADD 0xFFFF+1 gives 0 with `carry` = 1 and `zero` = 1.
  - MUL by 0 gives `zero` = 1 after the full WIDTH+1 cycles; there is no early exit.

## Configuration
- Macro `ALU_DIV_EN`.
- Defined: DIV datapath and DIV state are compiled in as described above.
- Undefined: no divider logic. `ctrl` = 111 completes in 1 cycle with result 0, `zero` = 1, `div_zero` = 0, `carry` = 0 and `LT` computed normally. The DIV state does not exist.

## Test plan
All scenarios use WIDTH=16.
- ADD: A=10, B=20 → result 30, `out_valid` 1 cycle after accept. Then A=30, B=20 → result 50, `LT` = 0.
- SUB: A=10, B=20 → result 0xFFF6, `LT` = 1, `carry` = 1, `zero` = 0. SLT on the same operands → result 1.
- MUL: A=300, B=300 → result 0x5F90, `out_valid` exactly 17 cycles after accept, `in_ready` = 0 throughout.
- DIV (with `ALU_DIV_EN`): A=100, B=7 → 14 after 17 cycles. A=5, B=0 → 0xFFFF with `div_zero` = 1 after 1 cycle. Without the macro, A=100, B=7 → 0 after 1 cycle.
- Backpressure: ADD 0xFFFF+1 with `out_ready` held low for 5 cycles → result 0, `carry` = 1, `zero` = 1, all stable. `in_ready` stays low and a concurrent `in_valid` is ignored until handoff.
- Reset mid-MUL: assert `reset` 5 cycles after a MUL accept → next cycle IDLE, all outputs 0. A following ADD 2+3 → result 5 with normal latency.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for alu_seq.
//   Request side : in_valid, in_ready, ctrl, input_a, input_b
//   Response side: out_valid, out_ready, alu_result, LT, zero, carry, div_zero
//   master modport = requester/consumer, slave modport = alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             LT;
  logic             zero;
  logic             carry;
  logic             div_zero;

  modport master (
    output in_valid, ctrl, input_a, input_b, out_ready,
    input  in_ready, out_valid, alu_result, LT, zero, carry, div_zero
  );

  modport slave (
    input  in_valid, ctrl, input_a, input_b, out_ready,
    output in_ready, out_valid, alu_result, LT, zero, carry, div_zero
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU, one operation in flight, registered result/flags.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : alu_seq_if.slave (valid/ready request in, valid/ready result out)
// Ops: ADD SUB AND OR XOR SLT complete in one cycle; MUL (shift-add) and
// DIV (restoring) take one operand bit per cycle, MSB first.
// Build option: define ALU_DIV_EN to include the divider; without it ctrl=111
// completes in one cycle with result 0.
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// MUL   | shift-add multiply, cnt = multiplier bit being consumed
// DIV   | restoring divide, cnt = dividend bit being consumed (ALU_DIV_EN only)
// DONE  | out_valid high, result held until out_ready
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
`ifdef ALU_DIV_EN
  localparam logic [1:0] S_DIV  = 2'd2;
`endif
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a, op_b, acc;
  logic [WIDTH-1:0] res_q;
  logic             lt_q, zero_q, carry_q, dz_q;

  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] simple_res;
  logic             simple_carry, simple_dz, in_lt, op_lt;
  logic [WIDTH-1:0] mul_next;

  always_comb begin
    add_full     = {1'b0, bus.input_a} + {1'b0, bus.input_b};
    in_lt        = $signed(bus.input_a) < $signed(bus.input_b);
    simple_res   = '0;
    simple_carry = 1'b0;
    simple_dz    = 1'b0;
    case (bus.ctrl)
      3'b000: begin
        simple_res   = add_full[WIDTH-1:0];
        simple_carry = add_full[WIDTH];
      end
      3'b001: begin
        simple_res   = bus.input_a - bus.input_b;
        simple_carry = bus.input_a < bus.input_b;
      end
      3'b010: simple_res = bus.input_a & bus.input_b;
      3'b011: simple_res = bus.input_a | bus.input_b;
      3'b100: simple_res = bus.input_a ^ bus.input_b;
      3'b101: simple_res = {{(WIDTH-1){1'b0}}, in_lt};
`ifdef ALU_DIV_EN
      // only taken straight to DONE when B is zero
      3'b111: begin
        simple_res = '1;
        simple_dz  = 1'b1;
      end
`endif
      default: simple_res = '0;
    endcase
  end

  // MSB-first shift-add keeps only the low WIDTH bits, which is all we need
  always_comb begin
    op_lt    = $signed(op_a) < $signed(op_b);
    mul_next = {acc[WIDTH-2:0], 1'b0} + (op_b[cnt] ? op_a : '0);
  end

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] rem, rem_next, div_next;
  logic [WIDTH:0]   rem_sh, div_diff;
  logic             div_ge;

  // rem < op_b always, so the shifted remainder fits WIDTH+1 bits and
  // bit WIDTH of the difference is a clean borrow
  always_comb begin
    rem_sh   = {rem, op_a[cnt]};
    div_diff = rem_sh - {1'b0, op_b};
    div_ge   = ~div_diff[WIDTH];
    rem_next = div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_next = {acc[WIDTH-2:0], div_ge};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      res_q   <= '0;
      lt_q    <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
`ifdef ALU_DIV_EN
      rem     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_a <= bus.input_a;
            op_b <= bus.input_b;
            acc  <= '0;
            cnt  <= CNT_TOP;
`ifdef ALU_DIV_EN
            rem  <= '0;
`endif
            if (bus.ctrl == 3'b110) begin
              state <= S_MUL;
`ifdef ALU_DIV_EN
            end else if (bus.ctrl == 3'b111 && bus.input_b != '0) begin
              state <= S_DIV;
`endif
            end else begin
              state   <= S_DONE;
              res_q   <= simple_res;
              lt_q    <= in_lt;
              zero_q  <= (simple_res == '0);
              carry_q <= simple_carry;
              dz_q    <= simple_dz;
            end
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state   <= S_DONE;
            res_q   <= mul_next;
            lt_q    <= op_lt;
            zero_q  <= (mul_next == '0);
            carry_q <= 1'b0;
            dz_q    <= 1'b0;
          end
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          acc <= div_next;
          rem <= rem_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state   <= S_DONE;
            res_q   <= div_next;
            lt_q    <= op_lt;
            zero_q  <= (div_next == '0);
            carry_q <= 1'b0;
            dz_q    <= 1'b0;
          end
        end
`endif
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.out_valid  = (state == S_DONE);
  assign bus.alu_result = res_q;
  assign bus.LT         = lt_q;
  assign bus.zero       = zero_q;
  assign bus.carry      = carry_q;
  assign bus.div_zero   = dz_q;
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int errors = 0;
  int checks = 0;

  // Reference: arithmetic straight from the op definitions.
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] res, output logic lt, output logic zr,
                                output logic cy, output logic dz, output int lat);
    longint ua, ub, sa, sb;
    ua = longint'(a);
    ub = longint'(b);
    sa = (a >= 16'h8000) ? ua - 65536 : ua;
    sb = (b >= 16'h8000) ? ub - 65536 : ub;
    lt = (sa < sb);
    cy = 1'b0;
    dz = 1'b0;
    lat = 1;
    res = '0;
    case (op)
      3'd0: begin res = 16'((ua + ub) % 65536); cy = (ua + ub) > 65535; end
      3'd1: begin res = 16'((ua - ub + 65536) % 65536); cy = (ua < ub); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = lt ? 16'd1 : 16'd0;
      3'd6: begin res = 16'((ua * ub) % 65536); lat = W + 1; end
      default: begin
`ifdef ALU_DIV_EN
        if (ub == 0) begin res = 16'hFFFF; dz = 1'b1; end
        else begin res = 16'(ua / ub); lat = W + 1; end
`else
        res = 16'd0;
`endif
      end
    endcase
    zr = (res == 16'd0);
  endfunction

  // Drives one request (caller is in IDLE), measures latency, optionally stalls, hands off.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int stall, output logic [15:0] res, output logic [3:0] flags,
                        output int lat, output logic rdy_seen, output logic unstable,
                        output logic timeout);
    bus.ctrl = op; bus.input_a = a; bus.input_b = b;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.input_a = 16'($urandom); bus.input_b = 16'($urandom); bus.ctrl = 3'($urandom);
    lat = 1; rdy_seen = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      if (bus.in_ready !== 1'b0) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    timeout = (bus.out_valid !== 1'b1);
    res = bus.alu_result;
    flags = {bus.LT, bus.zero, bus.carry, bus.div_zero};
    unstable = (bus.in_ready !== 1'b0);
    repeat (stall) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.alu_result !== res ||
          {bus.LT, bus.zero, bus.carry, bus.div_zero} !== flags) unstable = 1'b1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.alu_result !== 16'h0) begin errors++; $display("FAIL reset_result: got %h want 0000", bus.alu_result); end
    checks++; if ({bus.LT, bus.zero, bus.carry, bus.div_zero} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags: got %b want 0000", {bus.LT, bus.zero, bus.carry, bus.div_zero}); end
    reset = 1'b0;
  endtask

  task automatic test_add();
    logic [15:0] r; logic [3:0] f; int lat; logic rs, us, to;
    run_op(3'd0, 16'd10, 16'd20, 0, r, f, lat, rs, us, to);
    checks++; if (r !== 16'd30) begin errors++; $display("FAIL add1_result: got %0d want 30", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL add1_latency: got %0d want 1", lat); end
    run_op(3'd0, 16'd30, 16'd20, 0, r, f, lat, rs, us, to);
    checks++; if (r !== 16'd50) begin errors++; $display("FAIL add2_result: got %0d want 50", r); end
    checks++; if (f[3] !== 1'b0) begin errors++; $display("FAIL add2_lt: got %b want 0", f[3]); end
  endtask

  task automatic test_sub_slt();
    logic [15:0] r; logic [3:0] f; int lat; logic rs, us, to;
    run_op(3'd1, 16'd10, 16'd20, 0, r, f, lat, rs, us, to);
    checks++; if (r !== 16'hFFF6) begin errors++; $display("FAIL sub_result: got %h want fff6", r); end
    checks++; if (f !== 4'b1010) begin errors++; $display("FAIL sub_flags(lt,zero,carry,dz): got %b want 1010", f); end
    run_op(3'd5, 16'd10, 16'd20, 0, r, f, lat, rs, us, to);
    checks++; if (r !== 16'd1) begin errors++; $display("FAIL slt_result: got %0d want 1", r); end
  endtask

  task automatic test_mul();
    logic [15:0] r; logic [3:0] f; int lat; logic rs, us, to;
    run_op(3'd6, 16'd300, 16'd300, 0, r, f, lat, rs, us, to);
    checks++; if (r !== 16'h5F90) begin errors++; $display("FAIL mul_result: got %h want 5f90", r); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL mul_latency: got %0d want 17", lat); end
    checks++; if (rs !== 1'b0) begin errors++; $display("FAIL mul_in_ready_low: saw in_ready=1 while busy"); end
    run_op(3'd6, 16'h1234, 16'd0, 0, r, f, lat, rs, us, to);
    checks++; if (r !== 16'd0 || f[2] !== 1'b1) begin errors++; $display("FAIL mul0_result: got %h zero=%b want 0000 zero=1", r, f[2]); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL mul0_latency: got %0d want 17", lat); end
  endtask

  task automatic test_div();
    logic [15:0] r; logic [3:0] f; int lat; logic rs, us, to;
`ifdef ALU_DIV_EN
    run_op(3'd7, 16'd100, 16'd7, 0, r, f, lat, rs, us, to);
    checks++; if (r !== 16'd14) begin errors++; $display("FAIL div_result: got %0d want 14", r); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL div_latency: got %0d want 17", lat); end
    run_op(3'd7, 16'd5, 16'd0, 0, r, f, lat, rs, us, to);
    checks++; if (r !== 16'hFFFF || f[0] !== 1'b1) begin errors++; $display("FAIL div0_result: got %h dz=%b want ffff dz=1", r, f[0]); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency: got %0d want 1", lat); end
`else
    run_op(3'd7, 16'd100, 16'd7, 0, r, f, lat, rs, us, to);
    checks++; if (r !== 16'd0 || f !== 4'b0100) begin errors++; $display("FAIL nodiv_result: got %h flags=%b want 0000 flags=0100", r, f); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL nodiv_latency: got %0d want 1", lat); end
`endif
  endtask

  task automatic test_back_pressure();
    bus.ctrl = 3'd0; bus.input_a = 16'hFFFF; bus.input_b = 16'h0001;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    // a second request is presented and held across the stall
    bus.ctrl = 3'd2; bus.input_a = 16'h0F0F; bus.input_b = 16'h00FF;
    checks++; if (bus.out_valid !== 1'b1 || bus.alu_result !== 16'h0 || bus.carry !== 1'b1 || bus.zero !== 1'b1)
      begin errors++; $display("FAIL bp_first: valid=%b result=%h carry=%b zero=%b want 1 0000 1 1", bus.out_valid, bus.alu_result, bus.carry, bus.zero); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.alu_result !== 16'h0 || bus.carry !== 1'b1 || bus.zero !== 1'b1)
        begin errors++; $display("FAIL bp_hold%0d: valid=%b in_ready=%b result=%h carry=%b zero=%b", i, bus.out_valid, bus.in_ready, bus.alu_result, bus.carry, bus.zero); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_handoff: valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.alu_result !== 16'h000F)
      begin errors++; $display("FAIL bp_held_req: valid=%b result=%h want 1 000f", bus.out_valid, bus.alu_result); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    logic [15:0] r; logic [3:0] f; int lat; logic rs, us, to; logic seen;
    bus.ctrl = 3'd6; bus.input_a = 16'd300; bus.input_b = 16'd300; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.alu_result !== 16'h0 ||
                  {bus.LT, bus.zero, bus.carry, bus.div_zero} !== 4'b0000)
      begin errors++; $display("FAIL rst_mul_state: in_ready=%b valid=%b result=%h flags=%b", bus.in_ready, bus.out_valid, bus.alu_result, {bus.LT, bus.zero, bus.carry, bus.div_zero}); end
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (bus.out_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mul_abandon: out_valid=1 after reset, want 0"); end
    run_op(3'd0, 16'd2, 16'd3, 0, r, f, lat, rs, us, to);
    checks++; if (r !== 16'd5 || lat !== 1) begin errors++; $display("FAIL rst_mul_add: result=%0d lat=%0d want 5 1", r, lat); end
  endtask

  task automatic test_random();
    logic [15:0] a, b, r, er; logic [3:0] f; logic elt, ezr, ecy, edz;
    logic [2:0] op; int lat, elat, stall; logic rs, us, to;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      stall = $urandom_range(0, 2);
      run_op(op, a, b, stall, r, f, lat, rs, us, to);
      model(op, a, b, er, elt, ezr, ecy, edz, elat);
      checks++; if (r !== er || f !== {elt, ezr, ecy, edz})
        begin errors++; $display("FAIL rand%0d op=%0d a=%h b=%h: got %h/%b want %h/%b", n, op, a, b, r, f, er, {elt, ezr, ecy, edz}); end
      checks++; if (lat !== elat || rs !== 1'b0 || us !== 1'b0 || to !== 1'b0)
        begin errors++; $display("FAIL rand%0d_timing op=%0d: lat=%0d ready_seen=%b unstable=%b timeout=%b want lat=%0d 0 0 0", n, op, lat, rs, us, to, elat); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.ctrl = 3'd0; bus.input_a = '0; bus.input_b = '0;
    test_reset();
    test_add();
    test_sub_slt();
    test_mul();
    test_div();
    test_back_pressure();
    test_reset_mid_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
